// File: rtl/sipo_buffer.sv
// Serial-in, parallel-out block assembler: packs DEPTH words of WIDTH bits into one
// block, zero-padding a short final block, first word in the top lane.
module sipo_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH*WIDTH-1:0]   data_out,
  output logic                     out_last
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and payload is held stable while valid & !ready.

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [WIDTH-1:0]    slot_q [DEPTH];
  logic [WIDTH-1:0]    slot_d [DEPTH];
  logic                shift_en;
  logic [WIDTH-1:0]    shift_word;

  assign in_ready  = (state_q == ST_FILL) && !rst;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign cnt_inc   = cnt_q + CW'(1);

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign data_out[g*WIDTH +: WIDTH] = slot_q[g];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    shift_en   = 1'b0;
    shift_word = '0;
    case (state_q)
      ST_FILL: begin
        if (in_valid && in_ready) begin
          shift_en   = 1'b1;
          shift_word = data_in;
          cnt_d      = cnt_inc;
          if (cnt_inc == DEPTH_C) begin
            state_d = ST_FULL;
            last_d  = in_last;
          end else if (in_last) begin
            state_d = ST_PAD;
            last_d  = 1'b1;
          end
        end
      end
      ST_PAD: begin
        shift_en = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_inc == DEPTH_C) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready) begin
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Oldest word migrates toward the top lane as new words enter lane 0.
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    if (shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
      slot_d[0] = shift_word;
    end

    out_valid_d = (state_d == ST_FULL);
    out_last_d  = (state_d == ST_FULL) && last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_sipo_buffer.sv
// Bench for sipo_buffer: directed latency/padding/backpressure cases plus random
// round-trips on a DEPTH=4 and a DEPTH=1 instance, scored against a message-level model.
module tb_sipo_buffer;

  localparam int W  = 64;
  localparam int D  = 4;
  localparam int BW = W * D;
  localparam int W1 = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // DUT A: WIDTH=64, DEPTH=4
  logic          a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0;
  logic [W-1:0]  a_data_in = '0;
  logic          a_out_valid, a_out_ready, a_out_last;
  logic [BW-1:0] a_data_out;
  // DUT B: WIDTH=256, DEPTH=1
  logic          b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
  logic [W1-1:0] b_data_in = '0;
  logic          b_out_valid, b_out_ready, b_out_last;
  logic [W1-1:0] b_data_out;

  sipo_buffer #(.WIDTH(W), .DEPTH(D)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_data_out), .out_last(a_out_last)
  );

  sipo_buffer #(.WIDTH(W1), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .out_last(b_out_last)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // out_ready drivers: fixed level or random per cycle
  logic rand_ready = 1'b0;
  logic a_ready_fix = 1'b1;
  logic b_ready_fix = 1'b1;
  initial begin
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
  end
  always @(posedge clk) begin
    #2;
    a_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : a_ready_fix;
    b_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : b_ready_fix;
  end

  // scoreboard: message-level model, expected blocks as {last, block}
  logic [W-1:0]  a_msg_q[$];
  logic [BW:0]   a_exp_q[$];
  logic [W1:0]   b_exp_q[$];
  logic [BW-1:0] a_blk;
  logic [BW:0]   a_e;
  logic [W1:0]   b_e;

  always @(negedge clk) begin
    if (rst) begin
      a_msg_q.delete();
      a_exp_q.delete();
      b_exp_q.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_exp_q.size() == 0) check("a_spurious_block", 256'(a_out_valid), 256'd0);
        else begin
          a_e = a_exp_q.pop_front();
          check("a_block_data", a_data_out, a_e[BW-1:0]);
          check("a_block_last", 256'(a_out_last), 256'(a_e[BW]));
        end
      end
      if (a_in_valid && a_in_ready) begin
        a_msg_q.push_back(a_data_in);
        if (a_msg_q.size() == D || a_in_last) begin
          a_blk = '0;
          for (int i = 0; i < a_msg_q.size(); i++) a_blk[(D-1-i)*W +: W] = a_msg_q[i];
          a_exp_q.push_back({a_in_last, a_blk});
          a_msg_q.delete();
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (b_exp_q.size() == 0) check("b_spurious_block", 256'(b_out_valid), 256'd0);
        else begin
          b_e = b_exp_q.pop_front();
          check("b_block_data", b_data_out, b_e[W1-1:0]);
          check("b_block_last", 256'(b_out_last), 256'(b_e[W1]));
        end
      end
      if (b_in_valid && b_in_ready) b_exp_q.push_back({b_in_last, b_data_in});
    end
  end

  // driver tasks
  task automatic a_send(input logic [W-1:0] d, input logic last);
    int t = 0;
    logic acc;
    a_in_valid = 1'b1;
    a_data_in  = d;
    a_in_last  = last;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 300);
    if (!acc) check("a_send_timeout", 256'(acc), 256'd1);
    a_in_valid = 1'b0;
    a_data_in  = {$urandom, $urandom};
    a_in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic b_send(input logic [W1-1:0] d, input logic last);
    int t = 0;
    logic acc;
    b_in_valid = 1'b1;
    b_data_in  = d;
    b_in_last  = last;
    do begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 300);
    if (!acc) check("b_send_timeout", 256'(acc), 256'd1);
    b_in_valid = 1'b0;
    b_data_in  = {8{$urandom}};
    b_in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [BW-1:0] blk;
  logic [BW-1:0] exp_blk;
  int len;

  initial begin
    // reset and idle
    @(negedge clk);
    check("rst_in_ready", 256'(a_in_ready), 256'd0);
    check("rst_out_valid", 256'(a_out_valid), 256'd0);
    check("rst_data_out", a_data_out, 256'd0);
    check("rst_out_last", 256'(a_out_last), 256'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 256'(a_in_ready), 256'd1);
    check("idle_out_valid", 256'(a_out_valid), 256'd0);
    check("idle_data_out", a_data_out, 256'd0);
    @(posedge clk);
    #1;

    // reset mid-fill discards partial block
    a_send(64'h11, 1'b0);
    a_send(64'h12, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 256'(a_in_ready), 256'd1);
    check("midrst_out_valid", 256'(a_out_valid), 256'd0);
    check("midrst_data_out", a_data_out, 256'd0);
    @(posedge clk);
    #1;

    // full block back-to-back
    for (int i = 0; i < D; i++) a_send(64'hA0 + 64'(i), 1'b0);
    @(negedge clk);
    check("full_out_valid", 256'(a_out_valid), 256'd1);
    check("full_in_ready", 256'(a_in_ready), 256'd0);
    check("full_data", a_data_out, {64'hA0, 64'hA1, 64'hA2, 64'hA3});
    check("full_last", 256'(a_out_last), 256'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_out_valid_fall", 256'(a_out_valid), 256'd0);
    check("full_in_ready_back", 256'(a_in_ready), 256'd1);
    @(posedge clk);
    #1;

    // short final block: two PAD cycles
    a_send(64'hB0, 1'b0);
    a_send(64'hB1, 1'b1);
    for (int k = 0; k < D - 2; k++) begin
      @(negedge clk);
      check("pad_in_ready", 256'(a_in_ready), 256'd0);
      check("pad_out_valid", 256'(a_out_valid), 256'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("short_out_valid", 256'(a_out_valid), 256'd1);
    check("short_data", a_data_out, {64'hB0, 64'hB1, 64'h0, 64'h0});
    check("short_last", 256'(a_out_last), 256'd1);
    idle(2);

    // in_last on the DEPTH-th word: no PAD
    for (int i = 0; i < D; i++) a_send(64'hC0 + 64'(i), i == D - 1);
    @(negedge clk);
    check("lastfull_out_valid", 256'(a_out_valid), 256'd1);
    check("lastfull_data", a_data_out, {64'hC0, 64'hC1, 64'hC2, 64'hC3});
    check("lastfull_last", 256'(a_out_last), 256'd1);
    idle(2);

    // backpressure with ignored input pulses
    a_ready_fix = 1'b0;
    for (int i = 0; i < D; i++) a_send(64'hD0 + 64'(i), 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 256'(a_out_valid), 256'd1);
      check("bp_in_ready", 256'(a_in_ready), 256'd0);
      check("bp_data", a_data_out, {64'hD0, 64'hD1, 64'hD2, 64'hD3});
      check("bp_last", 256'(a_out_last), 256'd0);
      @(posedge clk);
      #1;
      a_in_valid = 1'($urandom_range(0, 1));
      a_data_in  = {$urandom, $urandom};
      a_in_last  = 1'($urandom_range(0, 1));
    end
    a_in_valid  = 1'b0;
    a_ready_fix = 1'b1;
    idle(2);
    for (int i = 0; i < D; i++) a_send(64'hE0 + 64'(i), 1'b0);
    @(negedge clk);
    check("after_bp_data", a_data_out, {64'hE0, 64'hE1, 64'hE2, 64'hE3});
    idle(2);

    // random round-trips: block serialized top lane first, random gaps and out_ready
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < BW / 32; j++) blk[j*32 +: 32] = $urandom;
      len = (n % 3 == 0) ? $urandom_range(1, D) : D;
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        a_send(blk[(D-1-i)*W +: W],
               (i == len - 1) && ((len < D) || ($urandom_range(0, 1) == 1)));
      end
    end
    for (int n = 0; n < 25; n++) begin
      idle($urandom_range(0, 2));
      b_send({8{$urandom}}, 1'($urandom_range(0, 1)));
    end

    // drain
    begin
      int t = 0;
      while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && t < 500) begin
        @(posedge clk);
        t++;
      end
    end
    check("a_drain", 256'(a_exp_q.size()), 256'd0);
    check("b_drain", 256'(b_exp_q.size()), 256'd0);
    rand_ready = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sipo_buffer.md
# sipo_buffer

Serial-in, parallel-out block assembler for the Keccak petalite datapath. It accepts WIDTH-bit words over a valid/ready stream and packs DEPTH of them into one DEPTH*WIDTH-bit block. A short final block is zero-padded, and the result is presented on a valid/ready output. Lane ordering is the exact inverse of the PISO serializer: a block serialized by the PISO and fed through this block reassembles bit-identically.

## Interface

Parameters:
- WIDTH, 64, bits per serial word (≥1)
- DEPTH, 17, words per block (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  data_in/in_last valid
- in_ready  out  1  block can accept a word
- data_in  in  WIDTH  serial word
- in_last  in  1  word is final of message; qualified by in_valid
- out_valid  out  1  data_out holds a complete block
- out_ready  in  1  consumer takes block
- data_out  out  DEPTH*WIDTH  assembled block
- out_last  out  1  block is final block of message; qualified by out_valid

## Operation

- Storage: DEPTH word registers slot[0..DEPTH-1], word counter cnt (0..DEPTH, $clog2(DEPTH+1) bits), last_q flag, state register.
- data_out[i*WIDTH +: WIDTH] = slot[i]. The first word accepted ends in slot[DEPTH-1]; the last ends in slot[0].
- Shift operation: slot[i] <= slot[i-1] for i = DEPTH-1..1; slot[0] <= new word.
- States:
  - FILL
    - in_ready=1.
    - On accept (in_valid & in_ready): shift in data_in, cnt += 1.
      - New cnt == DEPTH → FULL, last_q <= in_last.
      - Else, in_last=1 → PAD, last_q <= 1.
      - Else stay.
  - PAD
    - in_ready=0.
    - Each cycle: shift in zero word, cnt += 1.
    - When new cnt == DEPTH → FULL.
  - FULL
    - out_valid=1, out_last=last_q, in_ready=0.
    - On out_ready: cnt <= 0, last_q <= 0 → FILL.
    - Slots are not cleared. They are fully overwritten before the next FULL.
- in_last on the DEPTH-th word goes directly to FULL with out_last=1; no PAD cycles.
- DEPTH=1: every accepted word goes to FULL; PAD is unreachable.
- data_in is ignored when not accepted. Held data_out is stable throughout FULL.
- No accept/present overlap: in_ready is 0 in FULL, including the handshake cycle.
- Empty messages (in_last with no word) are not representable. The upstream block never issues them.

## Timing

- Reset: rst sampled high at an edge, regardless of state, gives:
  - state=FILL, cnt=0, last_q=0
  - all slots 0
  - out_valid=0, out_last=0, data_out=0
  - in_ready=0 while rst is high (in_ready = FILL & !rst); 1 from the first cycle after release.
- Reset mid-fill or mid-PAD discards the partial block. No output is produced for it.
- Accept-to-present latency:
  - out_valid rises the cycle after the edge that accepts the DEPTH-th word.
  - Partial block of k words: DEPTH-k PAD cycles, then out_valid.
- out_valid falls the cycle after the out_ready handshake edge. in_ready rises in that same cycle.
- Full-rate throughput with out_ready tied high: one block per DEPTH+1 cycles.
- out_valid/data_out/out_last are held indefinitely under backpressure (out_ready=0).
- All outputs are register-driven except in_ready, which is decoded from state and rst.

## Test plan

- Reset/idle (WIDTH=64, DEPTH=4), after releasing rst:
  - out_valid=0, data_out=0, in_ready=1.
  - Assert rst for 1 cycle mid-fill after 2 words: cnt returns to 0 and no block appears.
- Full block, words 0xA0..0xA3 back-to-back, out_ready=1:
  - out_valid is high for one cycle, 1 cycle after the 4th accept.
  - data_out = {0xA0,0xA1,0xA2,0xA3} with 0xA0 in the top lane.
  - out_last=0; in_ready returns the next cycle.
- Short final block, words 0xB0, 0xB1 with in_last on 0xB1:
  - 2 PAD cycles with in_ready=0.
  - Then data_out = {0xB0,0xB1,0,0}, out_last=1.
- in_last on the 4th word: FULL directly with no PAD cycles, out_last=1.
- Backpressure, out_ready=0 for 10 cycles during FULL:
  - data_out, out_valid and out_last are stable; in_ready=0.
  - in_valid pulses are ignored and do not alter the next block.
- Round-trip with random WIDTH-bit words, DEPTH=4 and DEPTH=1, random in_valid/out_ready gaps:
  - Serialize a random 256-bit block with piso_buffer and feed it here.
  - data_out equals the original block.
